// File: rtl/fetch_queue_unit_pkg.sv
// Shared defaults and helpers for the multi-instruction fetch stage.
package fetch_queue_unit_pkg;

  localparam int          FQ_ADDR_LEN    = 32;
  localparam int          FQ_INSN_LEN    = 32;
  localparam int          FQ_BLOCK_INSNS = 4;
  localparam int          FQ_DEC_WIDTH   = 2;
  localparam int          FQ_DEPTH       = 8;
  localparam logic [31:0] FQ_ENTRY_POINT = 32'h0000_0000;

  function automatic int unsigned fq_min(int unsigned a, int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_queue_unit_inst_queue.sv
// Circular {pc,inst} buffer: up to BLOCK_INSNS pushes and DEC_WIDTH pops per cycle, flushable.
module fetch_inst_queue
  import fetch_queue_unit_pkg::*;
#(
  parameter int ADDR_LEN    = FQ_ADDR_LEN,
  parameter int INSN_LEN    = FQ_INSN_LEN,
  parameter int BLOCK_INSNS = FQ_BLOCK_INSNS,
  parameter int DEC_WIDTH   = FQ_DEC_WIDTH,
  parameter int QDEPTH      = FQ_DEPTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic [$clog2(BLOCK_INSNS):0]          enq_n_i,
  input  logic [BLOCK_INSNS-1:0][INSN_LEN-1:0]  enq_inst_i,
  input  logic [BLOCK_INSNS-1:0][ADDR_LEN-1:0]  enq_pc_i,
  input  logic                                  deq_ready_i,
  output logic [$clog2(QDEPTH):0]               count_o,
  output logic [DEC_WIDTH-1:0]                  deq_valid_o,
  output logic [DEC_WIDTH-1:0][INSN_LEN-1:0]    deq_inst_o,
  output logic [DEC_WIDTH-1:0][ADDR_LEN-1:0]    deq_pc_o
);

  localparam int LQ = $clog2(QDEPTH);
  localparam int CW = LQ + 1;

  logic [LQ-1:0]                    head, tail;
  logic [CW-1:0]                    count, pop_n;
  logic [QDEPTH-1:0][INSN_LEN-1:0]  inst_mem;
  logic [QDEPTH-1:0][ADDR_LEN-1:0]  pc_mem;

  assign pop_n   = deq_ready_i ? CW'(fq_min(32'(count), DEC_WIDTH)) : '0;
  assign count_o = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // The upstream credit check must keep pushes within free space.
      assert (({1'b0, count} + (CW+1)'(enq_n_i)) <= (CW+1)'(QDEPTH));
      head  <= head + LQ'(pop_n);
      tail  <= tail + LQ'(enq_n_i);
      count <= count + CW'(enq_n_i) - pop_n;
    end
  end

  // Storage needs no reset; only entries below count are ever shown as valid.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int j = 0; j < BLOCK_INSNS; j++) begin
        if (j < int'(enq_n_i)) begin
          inst_mem[tail + LQ'(j)] <= enq_inst_i[j];
          pc_mem[tail + LQ'(j)]   <= enq_pc_i[j];
        end
      end
    end
  end

  for (genvar i = 0; i < DEC_WIDTH; i++) begin : g_rd
    logic [LQ-1:0] idx;
    assign idx            = head + LQ'(i);
    assign deq_valid_o[i] = count > CW'(i);
    assign deq_inst_o[i]  = inst_mem[idx];
    assign deq_pc_o[i]    = pc_mem[idx];
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage top: fetch PC, credit-gated block requests, response slicing, redirect priority.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int                 ADDR_LEN    = FQ_ADDR_LEN,
  parameter int                 INSN_LEN    = FQ_INSN_LEN,
  parameter int                 BLOCK_INSNS = FQ_BLOCK_INSNS,
  parameter int                 DEC_WIDTH   = FQ_DEC_WIDTH,
  parameter int                 QDEPTH      = FQ_DEPTH,
  parameter logic [ADDR_LEN-1:0] ENTRY_POINT = ADDR_LEN'(FQ_ENTRY_POINT)
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  output logic                            imem_req_o,
  output logic [ADDR_LEN-1:0]             imem_addr_o,
  input  logic [BLOCK_INSNS*INSN_LEN-1:0] imem_data_i,
  input  logic                            redirect_i,
  input  logic [ADDR_LEN-1:0]             redirect_pc_i,
  output logic [DEC_WIDTH-1:0]            deq_valid_o,
  output logic [DEC_WIDTH*INSN_LEN-1:0]   deq_inst_o,
  output logic [DEC_WIDTH*ADDR_LEN-1:0]   deq_pc_o,
  input  logic                            deq_ready_i
);

  localparam int LB = $clog2(BLOCK_INSNS);
  localparam int NW = LB + 1;
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [ADDR_LEN-1:0] fpc, base_q;
  logic [LB-1:0]       off, off_q;
  logic [NW-1:0]       n, n_q, pend_n, enq_n;
  logic                req_q, req;
  logic [CW-1:0]       count;
  logic [CW+1:0]       need;

  logic [BLOCK_INSNS-1:0][INSN_LEN-1:0] blk, enq_inst;
  logic [BLOCK_INSNS-1:0][ADDR_LEN-1:0] enq_pc;

  assign off         = fpc[LB+1:2];
  assign n           = NW'(BLOCK_INSNS) - NW'(off);
  assign imem_addr_o = {fpc[ADDR_LEN-1:LB+2], {(LB+2){1'b0}}};

  // Credit counts the in-flight response too, so a worst-case block always fits.
  assign pend_n     = req_q ? n_q : '0;
  assign need       = (CW+2)'(count) + (CW+2)'(pend_n) + (CW+2)'(BLOCK_INSNS);
  assign req        = reset_ni & ~redirect_i & (need <= (CW+2)'(QDEPTH));
  assign imem_req_o = req;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fpc    <= ENTRY_POINT;
      req_q  <= 1'b0;
      n_q    <= '0;
      off_q  <= '0;
      base_q <= '0;
    end else if (redirect_i) begin
      fpc   <= redirect_pc_i;
      req_q <= 1'b0;
    end else begin
      req_q <= req;
      if (req) begin
        fpc    <= imem_addr_o + ADDR_LEN'(4 * BLOCK_INSNS);
        n_q    <= n;
        off_q  <= off;
        base_q <= imem_addr_o;
      end
    end
  end

  // Compact the returned block so lane j carries block slot off_q+j.
  assign blk   = imem_data_i;
  assign enq_n = (req_q & ~redirect_i) ? n_q : '0;

  for (genvar j = 0; j < BLOCK_INSNS; j++) begin : g_slice
    logic [LB-1:0] slot;
    assign slot        = off_q + LB'(j);
    assign enq_inst[j] = blk[slot];
    assign enq_pc[j]   = base_q + ADDR_LEN'({slot, 2'b00});
  end

  fetch_inst_queue #(
    .ADDR_LEN    (ADDR_LEN),
    .INSN_LEN    (INSN_LEN),
    .BLOCK_INSNS (BLOCK_INSNS),
    .DEC_WIDTH   (DEC_WIDTH),
    .QDEPTH      (QDEPTH)
  ) u_q (
    .clk_i       (clk_i),
    .rst_ni      (reset_ni),
    .flush_i     (redirect_i),
    .enq_n_i     (enq_n),
    .enq_inst_i  (enq_inst),
    .enq_pc_i    (enq_pc),
    .deq_ready_i (deq_ready_i),
    .count_o     (count),
    .deq_valid_o (deq_valid_o),
    .deq_inst_o  (deq_inst_o),
    .deq_pc_o    (deq_pc_o)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit; memory returns inst == its own address.
module tb_fetch_queue_unit;

  localparam int AL = 32;
  localparam int IL = 32;
  localparam int BI = 4;
  localparam int DW = 2;

  logic              clk_i, reset_ni;
  logic              imem_req_o;
  logic [AL-1:0]     imem_addr_o;
  logic [BI*IL-1:0]  imem_data_i;
  logic              redirect_i;
  logic [AL-1:0]     redirect_pc_i;
  logic [DW-1:0]     deq_valid_o;
  logic [DW*IL-1:0]  deq_inst_o;
  logic [DW*AL-1:0]  deq_pc_o;
  logic              deq_ready_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  fetch_queue_unit #(
    .ADDR_LEN(AL), .INSN_LEN(IL), .BLOCK_INSNS(BI), .DEC_WIDTH(DW), .QDEPTH(8),
    .ENTRY_POINT(32'h0)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_data_i(imem_data_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .deq_valid_o(deq_valid_o), .deq_inst_o(deq_inst_o), .deq_pc_o(deq_pc_o),
    .deq_ready_i(deq_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // 1-cycle-latency instruction memory
  always @(posedge clk_i) begin
    if (imem_req_o)
      for (int i = 0; i < BI; i++) imem_data_i[i*IL +: IL] <= imem_addr_o + 32'(4*i);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (deq_valid_o[0] !== 1'b1 && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, 64'(deq_valid_o[0]), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; deq_ready_i = 1'b1;
    imem_data_i = '0;

    // Reset
    repeat (3) @(negedge clk_i);
    chk("rst_req", 64'(imem_req_o), 0);
    chk("rst_valid", 64'(deq_valid_o), 0);
    reset_ni = 1'b1;
    #1;
    chk("post_rst_req", 64'(imem_req_o), 1);
    chk("post_rst_addr", 64'(imem_addr_o), 0);
    chk("post_rst_valid", 64'(deq_valid_o), 0);

    // Straight-line stream, two per cycle after fill
    wait_valid("t2_fill");
    exp_pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      chk("t2_valid", 64'(deq_valid_o), 64'b11);
      chk("t2_pc0", 64'(deq_pc_o[31:0]), 64'(exp_pc));
      chk("t2_pc1", 64'(deq_pc_o[63:32]), 64'(exp_pc + 32'd4));
      chk("t2_inst0", 64'(deq_inst_o[31:0]), 64'(exp_pc));
      exp_pc += 32'd8;
      @(negedge clk_i);
    end

    // Unaligned redirect to 0x108
    redirect_i = 1'b1; redirect_pc_i = 32'h108;
    #1 chk("t3_req_during_redir", 64'(imem_req_o), 0);
    @(negedge clk_i);
    redirect_i = 1'b0;
    #1;
    chk("t3_valid_after", 64'(deq_valid_o), 0);
    chk("t3_req", 64'(imem_req_o), 1);
    chk("t3_addr", 64'(imem_addr_o), 64'h100);
    @(negedge clk_i);
    chk("t3_next_req", 64'(imem_req_o), 1);
    chk("t3_next_addr", 64'(imem_addr_o), 64'h110);
    chk("t3_valid_empty", 64'(deq_valid_o), 0);
    @(negedge clk_i);
    chk("t3_valid2", 64'(deq_valid_o), 64'b11);
    chk("t3_pc0", 64'(deq_pc_o[31:0]), 64'h108);
    chk("t3_pc1", 64'(deq_pc_o[63:32]), 64'h10C);
    chk("t3_inst0", 64'(deq_inst_o[31:0]), 64'h108);
    @(negedge clk_i);
    chk("t3_pc_after", 64'(deq_pc_o[31:0]), 64'h110);

    // Backpressure: queue fills to 8, requests stop
    deq_ready_i = 1'b0;
    repeat (4) @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      chk("t4_req_stall", 64'(imem_req_o), 0);
      chk("t4_pc0_hold", 64'(deq_pc_o[31:0]), 64'h110);
      @(negedge clk_i);
    end
    deq_ready_i = 1'b1;
    exp_pc = 32'h110;
    for (int i = 0; i < 10; i++) begin
      chk("t4_valid", 64'(deq_valid_o), 64'b11);
      chk("t4_pc0", 64'(deq_pc_o[31:0]), 64'(exp_pc));
      chk("t4_pc1", 64'(deq_pc_o[63:32]), 64'(exp_pc + 32'd4));
      exp_pc += 32'd8;
      @(negedge clk_i);
    end

    // Redirect in the same cycle as a response
    for (int i = 0; i < 6 && imem_req_o !== 1'b1; i++) @(negedge clk_i);
    chk("t5_found_req", 64'(imem_req_o), 1);
    @(negedge clk_i);
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    #1 chk("t5_req_during_redir", 64'(imem_req_o), 0);
    @(negedge clk_i);
    redirect_i = 1'b0;
    #1;
    chk("t5_valid_after", 64'(deq_valid_o), 0);
    chk("t5_req", 64'(imem_req_o), 1);
    chk("t5_addr", 64'(imem_addr_o), 64'h200);
    @(negedge clk_i);
    chk("t5_valid_empty", 64'(deq_valid_o), 0);
    chk("t5_next_addr", 64'(imem_addr_o), 64'h210);
    @(negedge clk_i);
    chk("t5_valid2", 64'(deq_valid_o), 64'b11);
    chk("t5_pc0", 64'(deq_pc_o[31:0]), 64'h200);
    chk("t5_inst1", 64'(deq_inst_o[63:32]), 64'h204);

    // Async reset between clock edges
    #2 reset_ni = 1'b0;
    #1;
    chk("t6_req_in_rst", 64'(imem_req_o), 0);
    chk("t6_valid_in_rst", 64'(deq_valid_o), 0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    chk("t6_req", 64'(imem_req_o), 1);
    chk("t6_addr", 64'(imem_addr_o), 0);
    wait_valid("t6_fill");
    chk("t6_pc0", 64'(deq_pc_o[31:0]), 0);
    chk("t6_pc1", 64'(deq_pc_o[63:32]), 64'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
